// File: rtl/seq_slice_alu.sv
// Bit-serial-by-slice adder/subtractor: one SLICE-bit chunk per clock,
// valid/ready handshake on both sides, flags registered with the last slice.
module seq_slice_alu #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             carry,
    output logic             parity,
    output logic             overflow
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("seq_slice_alu: WIDTH must be an integer multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, z_reg, z_next;
    logic [IDXW-1:0]  idx_reg;
    logic             c_reg;
    logic             sign_reg, zero_reg, carry_reg, parity_reg, overflow_reg;
    logic [SLICE-1:0] a_sl, b_sl;
    logic [SLICE:0]   sl_sum;
    logic             carry_into_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (idx_reg == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One slice of the ripple add; the MSB's own inputs recover its carry-in
    // so overflow can be formed without a second adder.
    always_comb begin
        a_sl   = a_reg[idx_reg*SLICE +: SLICE];
        b_sl   = b_reg[idx_reg*SLICE +: SLICE];
        sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, c_reg};
        z_next = z_reg;
        z_next[idx_reg*SLICE +: SLICE] = sl_sum[SLICE-1:0];
        carry_into_msb = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sl_sum[SLICE-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            z_reg        <= '0;
            idx_reg      <= '0;
            c_reg        <= 1'b0;
            sign_reg     <= 1'b0;
            zero_reg     <= 1'b0;
            carry_reg    <= 1'b0;
            parity_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // op[0] marks the subtracting forms, op[1] the carry-in forms
                        a_reg   <= x;
                        b_reg   <= op[0] ? ~y : y;
                        c_reg   <= op[1] ? cin : op[0];
                        idx_reg <= '0;
                    end
                end
                RUN: begin
                    z_reg <= z_next;
                    c_reg <= sl_sum[SLICE];
                    if (idx_reg == LAST_IDX) begin
                        idx_reg      <= '0;
                        sign_reg     <= z_next[WIDTH-1];
                        zero_reg     <= ~|z_next;
                        carry_reg    <= sl_sum[SLICE];
                        parity_reg   <= ^z_next;
                        overflow_reg <= carry_into_msb ^ sl_sum[SLICE];
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign z        = z_reg;
    assign sign     = sign_reg;
    assign zero     = zero_reg;
    assign carry    = carry_reg;
    assign parity   = parity_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_seq_slice_alu.sv
// Randomized self-checking bench for seq_slice_alu against an arithmetic
// reference model, plus literal checks on known operand pairs.
module tb_seq_slice_alu;
    localparam int W  = 16;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, out_ready, cin;
    logic [1:0]    op;
    logic [W-1:0]  x, y;
    logic          in_ready, out_valid;
    logic [W-1:0]  z;
    logic          sign, zero, carry, parity, overflow;
    logic [4:0]    dflags;

    int total = 0;
    int bad   = 0;

    seq_slice_alu #(.WIDTH(W), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .x(x), .y(y), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .sign(sign), .zero(zero),
        .carry(carry), .parity(parity), .overflow(overflow)
    );

    always #5 clk = ~clk;
    assign dflags = {sign, zero, carry, parity, overflow};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {z, sign, zero, carry, parity, overflow} from plain integer arithmetic.
    function automatic logic [20:0] ref_alu(input logic [1:0] o, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        logic [15:0] bb, r;
        int c0, full, low, co, cmsb;
        bb   = (o == 2'd1 || o == 2'd3) ? ~b : b;
        c0   = (o == 2'd0) ? 0 : (o == 2'd1) ? 1 : int'(c);
        full = int'(a) + int'(bb) + c0;
        r    = full[15:0];
        co   = (full >> 16) & 1;
        low  = int'(a[14:0]) + int'(bb[14:0]) + c0;
        cmsb = (low >> 15) & 1;
        return {r, r[15], (r == 16'd0), co[0], ^r, cmsb[0] ^ co[0]};
    endfunction

    // Protocol-level model: an accepted op becomes visible NS edges later and
    // stays until consumed.
    logic          m_pending = 1'b0;
    int            m_left    = 0;
    logic [15:0]   m_z = '0, st_z = '0;
    logic [4:0]    m_f = '0, st_f = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending = 1'b0; m_left = 0; m_z = '0; m_f = '0;
        end else if (!m_pending) begin
            if (in_valid) begin
                {st_z, st_f} = ref_alu(op, x, y, cin);
                m_pending = 1'b1;
                m_left    = NS;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_z = st_z; m_f = st_f;
            end
        end else if (out_ready) begin
            m_pending = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready", 32'(in_ready), 32'(!m_pending));
            chk("out_valid", 32'(out_valid), 32'(m_pending && m_left == 0));
            if (!(m_pending && m_left > 0)) begin
                chk("model_z", 32'(z), 32'(m_z));
                chk("model_flags", 32'(dflags), 32'(m_f));
            end
        end
    end

    task automatic scramble(input bit junk_valid);
        x  = 16'($urandom);
        y  = 16'($urandom);
        op = 2'($urandom);
        cin = 1'($urandom);
        in_valid = junk_valid ? 1'($urandom) : 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input int stall, input bit junk,
                         output logic [15:0] rz, output logic [4:0] rf, output int lat);
        in_valid = 1'b1; op = o; x = a; y = b; cin = c;
        @(negedge clk);
        scramble(junk);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            scramble(junk);
        end
        rz = z;
        rf = dflags;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            scramble(1'b1);
            chk("hold_z", 32'(z), 32'(rz));
            chk("hold_flags", 32'(dflags), 32'(rf));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    logic [1:0]  d_op [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
    logic [15:0] d_x  [6] = '{16'h8fff, 16'hfffe, 16'haaaa, 16'h8000, 16'h0000, 16'h0005};
    logic [15:0] d_y  [6] = '{16'h8000, 16'h0002, 16'h5555, 16'h0001, 16'h0001, 16'h0003};
    logic [15:0] d_z  [6] = '{16'h0fff, 16'h0000, 16'hffff, 16'h7fff, 16'hffff, 16'h0001};
    logic [4:0]  d_f  [6] = '{5'b00101, 5'b01100, 5'b10000, 5'b00111, 5'b10000, 5'b00110};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rz, ra, rb;
        logic [4:0]  rf;
        logic [20:0] mres;
        logic [1:0]  ro;
        logic        rc;
        int          lat;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; x = '0; y = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_flags", 32'(dflags), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            mres = ref_alu(d_op[i], d_x[i], d_y[i], 1'b0);
            chk("ref_pin", 32'(mres), 32'({d_z[i], d_f[i]}));
            do_op(d_op[i], d_x[i], d_y[i], 1'b0, i % 2, 1'b1, rz, rf, lat);
            chk("dir_latency", 32'(lat), 32'(NS));
            chk("dir_z", 32'(rz), 32'(d_z[i]));
            chk("dir_flags", 32'(rf), 32'(d_f[i]));
            $display("directed op=%0d x=%h y=%h -> z=%h flags=%b lat=%0d", d_op[i], d_x[i], d_y[i], rz, rf, lat);
        end

        do_op(2'd0, 16'h1234, 16'h4321, 1'b0, 10, 1'b1, rz, rf, lat);
        chk("bp_z", 32'(rz), 32'h5555);
        chk("bp_flags", 32'(rf), 32'({5'b00000}));
        $display("backpressure ADD 1234+4321 -> z=%h flags=%b", rz, rf);

        in_valid = 1'b1; op = 2'd0; x = 16'h0f0f; y = 16'h0101; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_in_ready", 32'(in_ready), 32'd1);
        chk("midrun_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_z", 32'(z), 32'd0);
        chk("midrun_flags", 32'(dflags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_ghost_valid", 32'(out_valid), 32'd0);
        end
        $display("mid-run reset: operation discarded");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom); ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            mres = ref_alu(ro, ra, rb, rc);
            do_op(ro, ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom), rz, rf, lat);
            chk("rnd_latency", 32'(lat), 32'(NS));
            chk("rnd_result", 32'({rz, rf}), 32'(mres));
            $display("random op=%0d x=%h y=%h cin=%0d -> z=%h flags=%b", ro, ra, rb, rc, rz, rf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_slice_alu.md
SEQ_SLICE_ALU -- requirements
Module: seq_slice_alu

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter: SLICE, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of SLICE, otherwise elaboration SHALL fail.
REQ-003 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  operation request.
REQ-006 Port: in_ready  output  1  block can accept an operation.
REQ-007 Port: op  input  2  operation code: 00 ADD x+y; 01 SUB x-y; 10 ADC x+y+cin; 11 SBC x+~y+cin.
REQ-008 Port: x, y  input  WIDTH each  operands.
REQ-009 Port: cin  input  1  carry-in; used only by ADC and SBC.
REQ-010 Port: out_valid  output  1  result and flags are valid.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: z  output  WIDTH  result.
REQ-013 Port: sign, zero, carry, parity, overflow  output  1 each  result flags.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, in_valid=1 at a rising edge SHALL do all of the following:
- latch x and y, with y replaced by ~y for SUB and SBC;
- set the initial carry: 0 for ADD, 1 for SUB, cin for ADC and SBC;
- clear the slice index to 0;
- enter RUN.
REQ-016 In RUN, each cycle SHALL add slice[idx] of both latched operands plus the running carry, write the sum into slice[idx] of the result register, update the running carry, and increment idx.
REQ-017 Once the slice with idx = WIDTH/SLICE-1 is written, the FSM SHALL enter DONE and register all flags on that same edge.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH/SLICE clock edges after the accepting edge (4 for the defaults).
REQ-019 sign SHALL equal z[WIDTH-1].
REQ-020 zero SHALL be 1 when z equals 0.
REQ-021 carry SHALL be the carry out of bit WIDTH-1; for SUB/SBC, carry=1 means no borrow.
REQ-022 parity SHALL be the XOR of all bits of z (1 when the count of ones is odd).
REQ-023 overflow SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-024 In DONE, z and all flags SHALL hold stable while out_ready=0; out_valid=1 with out_ready=1 at an edge SHALL return the FSM to IDLE.
REQ-025 in_valid SHALL be ignored outside IDLE; no request is queued or lost-acknowledged.
REQ-026 Changes on x, y, op or cin after the accepting edge SHALL NOT affect the result in progress.
REQ-027 Back-to-back operation: the earliest next acceptance is the edge after the out_valid/out_ready handshake edge.

Reset
REQ-028 rst_n=0 SHALL, asynchronously and at any time including mid-RUN or in DONE, force:
- state to IDLE, with in_ready=1 and out_valid=0;
- z=0 and idx=0;
- sign=0, zero=0, carry=0, parity=0, overflow=0.
REQ-029 An operation interrupted by reset SHALL be discarded, and no out_valid SHALL be produced for it after rst_n returns to 1.

Verification (WIDTH=16, SLICE=4)
REQ-030 ADD x=8fff, y=8000 -> after 4 cycles: z=0fff, sign=0, zero=0, carry=1, parity=0, overflow=1.
REQ-031 ADD x=fffe, y=0002 -> z=0000, zero=1, carry=1, overflow=0, sign=0, parity=0.
REQ-032 ADD x=aaaa, y=5555 -> z=ffff, sign=1, carry=0, overflow=0, parity=0. Then SUB x=8000, y=0001 -> z=7fff, carry=1, overflow=1, parity=1.
REQ-033 SUB x=0000, y=0001 -> z=ffff, carry=0 (borrow), sign=1, overflow=0. Then SBC x=0005, y=0003, cin=0 -> z=0001, carry=1.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new operands driven -> z and flags unchanged, in_ready=0, and the next operation is accepted only after the handshake.
REQ-035 Assert rst_n=0 for 1 cycle in the 2nd RUN cycle -> in_ready=1, out_valid=0 and all outputs 0 immediately; no out_valid appears for the interrupted operation.
